// File: rtl/hawk_rd_arb.sv
// Shared AXI4 read-channel arbiter: round-robin AR grant into a single AR stage,
// with an in-order owner FIFO that steers R beats back to the issuing requester.
module hawk_rd_arb #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int OUTSTD  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_arvalid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr_i,
    input  logic [NUM_REQ*8-1:0]      req_arlen_i,
    output logic [NUM_REQ-1:0]        req_arready_o,
    output logic [NUM_REQ-1:0]        req_rvalid_o,
    input  logic [NUM_REQ-1:0]        req_rready_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      m_arvalid_o,
    output logic [ADDR_W-1:0]         m_araddr_o,
    output logic [7:0]                m_arlen_o,
    input  logic                      m_arready_i,
    input  logic                      m_rvalid_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rlast_i,
    output logic                      m_rready_o,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
    localparam int CNT_W = $clog2(OUTSTD) + 1;

    // Reduce an index in [0, 2*NUM_REQ-2] back into [0, NUM_REQ-1].
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] v);
        if (v >= (IDX_W+1)'(NUM_REQ)) begin
            return IDX_W'(v - (IDX_W+1)'(NUM_REQ));
        end else begin
            return v[IDX_W-1:0];
        end
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTD - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic                 arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]    araddr_q,  araddr_d;
    logic [7:0]           arlen_q,   arlen_d;
    logic [IDX_W-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 err_q,     err_d;
    logic [IDX_W-1:0]     owner_q [OUTSTD];

    logic                 win_found_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [IDX_W-1:0]     cand_s;
    logic                 can_grant_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_empty_s;
    logic [IDX_W-1:0]     head_s;
    logic [NUM_REQ-1:0]   rvalid_s;
    logic                 rready_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [7:0]           sel_len_s;

    assign fifo_empty_s = (cnt_q == '0);
    assign can_grant_s  = ~arvalid_q & (cnt_q < CNT_W'(OUTSTD));
    assign head_s       = owner_q[rd_ptr_q];
    assign sel_addr_s   = req_araddr_i[int'(win_idx_s)*ADDR_W +: ADDR_W];
    assign sel_len_s    = req_arlen_i[int'(win_idx_s)*8 +: 8];

    // Round-robin scan: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = wrap_idx({1'b0, rr_ptr_q} + (IDX_W+1)'(k));
            if (!win_found_s && req_arvalid_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // One-hot grant; only ever raised when the AR stage and FIFO have room.
    always_comb begin
        grant_s = '0;
        if (can_grant_s && win_found_s) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign push_s = |grant_s;

    // R steering: head owner sees the beat; empty FIFO drains strays.
    always_comb begin
        rvalid_s = '0;
        rready_s = 1'b1;
        if (!fifo_empty_s) begin
            rvalid_s[head_s] = m_rvalid_i;
            rready_s         = req_rready_i[head_s];
        end else begin
            rvalid_s = '0;
            rready_s = 1'b1;
        end
    end

    assign pop_s = m_rvalid_i & rready_s & m_rlast_i & ~fifo_empty_s;

    // AR stage and round-robin pointer next state.
    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        rr_ptr_d  = rr_ptr_q;
        if (push_s) begin
            arvalid_d = 1'b1;
            araddr_d  = sel_addr_s;
            arlen_d   = sel_len_s;
            rr_ptr_d  = wrap_idx({1'b0, win_idx_s} + (IDX_W+1)'(1));
        end else if (arvalid_q && m_arready_i) begin
            arvalid_d = 1'b0;
        end else begin
            arvalid_d = arvalid_q;
        end
    end

    // Owner FIFO pointer/count next state and sticky stray-beat error.
    always_comb begin
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (m_rvalid_i && fifo_empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // AR stage, round-robin pointer and error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= 8'd0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    // Owner FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < OUTSTD; i++) begin
                owner_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_s) begin
                owner_q[wr_ptr_q] <= win_idx_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_arready_o = grant_s;
    assign req_rvalid_o  = rvalid_s;
    assign m_rready_o    = rready_s;
    assign rdata_o       = m_rdata_i;
    assign rresp_o       = m_rresp_i;
    assign rlast_o       = m_rlast_i;
    assign m_arvalid_o   = arvalid_q;
    assign m_araddr_o    = araddr_q;
    assign m_arlen_o     = arlen_q;
    assign busy_o        = ~fifo_empty_s | arvalid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_hawk_rd_arb.sv
// Directed bench for hawk_rd_arb: a queue-based transaction model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_hawk_rd_arb;
    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int OS = 4;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_arvalid_i;
    logic [N*AW-1:0]   req_araddr_i;
    logic [N*8-1:0]    req_arlen_i;
    logic [N-1:0]      req_arready_o;
    logic [N-1:0]      req_rvalid_o;
    logic [N-1:0]      req_rready_i;
    logic [DW-1:0]     rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              m_arvalid_o;
    logic [AW-1:0]     m_araddr_o;
    logic [7:0]        m_arlen_o;
    logic              m_arready_i;
    logic              m_rvalid_i;
    logic [DW-1:0]     m_rdata_i;
    logic [1:0]        m_rresp_i;
    logic              m_rlast_i;
    logic              m_rready_o;
    logic              busy_o;
    logic              err_o;

    always #5 clk = ~clk;

    hawk_rd_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .OUTSTD(OS)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_arvalid_i(req_arvalid_i), .req_araddr_i(req_araddr_i),
        .req_arlen_i(req_arlen_i), .req_arready_o(req_arready_o),
        .req_rvalid_o(req_rvalid_o), .req_rready_i(req_rready_i),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .m_arvalid_o(m_arvalid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
        .m_arready_i(m_arready_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i), .m_rready_o(m_rready_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model state
    bit            mdl_arv;
    logic [AW-1:0] mdl_addr;
    logic [7:0]    mdl_len;
    int            mdl_rr;
    int            mdl_own[$];
    bit            mdl_err;
    int            glog[$];
    int            gcyc[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, then model advance for the coming edge.
    always @(negedge clk) begin
        int w;
        bit can;
        bit mrr;
        logic [N-1:0] e_ar;
        logic [N-1:0] e_rv;
        cyc++;
        if (!rst_ni) begin
            mdl_arv  = 1'b0;
            mdl_addr = '0;
            mdl_len  = 8'd0;
            mdl_rr   = 0;
            mdl_own.delete();
            mdl_err  = 1'b0;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req_arvalid_i[(mdl_rr + k) % N]) w = (mdl_rr + k) % N;
        end
        can  = !mdl_arv && (mdl_own.size() < OS);
        e_ar = '0;
        if (can && w >= 0) e_ar[w] = 1'b1;
        e_rv = '0;
        mrr  = 1'b1;
        if (mdl_own.size() > 0) begin
            e_rv[mdl_own[0]] = m_rvalid_i;
            mrr = req_rready_i[mdl_own[0]];
        end
        chk("m_arready", req_arready_o, e_ar);
        chk("m_rvalid", req_rvalid_o, e_rv);
        chk("m_rready", m_rready_o, mrr);
        chk("m_arvalid", m_arvalid_o, mdl_arv);
        chk("m_araddr", m_araddr_o, mdl_addr);
        chk("m_arlen", m_arlen_o, mdl_len);
        chk("m_busy", busy_o, (mdl_own.size() > 0) || mdl_arv);
        chk("m_err", err_o, mdl_err);
        chk("m_rdata", rdata_o, m_rdata_i);
        chk("m_rresp_rlast", {rresp_o, rlast_o}, {m_rresp_i, m_rlast_i});
        for (int k = 0; k < N; k++) begin
            if (req_arready_o[k]) begin
                glog.push_back(k);
                gcyc.push_back(cyc);
            end
        end
        if (rst_ni) begin
            if (m_rvalid_i && mdl_own.size() == 0) mdl_err = 1'b1;
            if (m_rvalid_i && mrr && m_rlast_i && mdl_own.size() > 0) void'(mdl_own.pop_front());
            if (mdl_arv && m_arready_i) mdl_arv = 1'b0;
            if (can && w >= 0) begin
                mdl_own.push_back(w);
                mdl_arv  = 1'b1;
                mdl_addr = req_araddr_i[w*AW +: AW];
                mdl_len  = req_arlen_i[w*8 +: 8];
                mdl_rr   = (w + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [5:0] rdy_pat;
        logic [5:0] last_pat;
        req_arvalid_i = '0;
        req_araddr_i  = '0;
        req_arlen_i   = '0;
        req_rready_i  = '0;
        m_arready_i   = 1'b0;
        m_rvalid_i    = 1'b0;
        m_rdata_i     = '0;
        m_rresp_i     = 2'b00;
        m_rlast_i     = 1'b0;

        // Reset values
        repeat (2) tick();
        #5;
        chk("rst_m_rready", m_rready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_arready", req_arready_o, 3'b000);
        chk("rst_m_arvalid", m_arvalid_o, 1'b0);
        tick();
        rst_ni = 1'b1;

        // Single request from requester 1
        tick();
        req_arvalid_i = 3'b010;
        req_araddr_i[1*AW +: AW] = 64'h1000;
        req_arlen_i[15:8] = 8'd0;
        m_arready_i  = 1'b1;
        req_rready_i = 3'b111;
        #5 chk("t1_grant", req_arready_o, 3'b010);
        tick();
        req_arvalid_i = 3'b000;
        #5 chk("t1_m_arvalid", m_arvalid_o, 1'b1);
        chk("t1_m_araddr", m_araddr_o, 64'h1000);
        tick();
        m_rvalid_i = 1'b1;
        m_rlast_i  = 1'b1;
        m_rdata_i  = {16{32'hA5A5_0001}};
        #5 chk("t1_rvalid", req_rvalid_o, 3'b010);
        chk("t1_arvalid_clr", m_arvalid_o, 1'b0);
        chk("t1_busy_inflight", busy_o, 1'b1);
        tick();
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        #5 chk("t1_busy_idle", busy_o, 1'b0);

        // Round-robin fairness with all requesters valid
        pulse_reset();
        glog.delete();
        gcyc.delete();
        m_arready_i  = 1'b1;
        req_rready_i = 3'b111;
        for (int c = 0; c < 12; c++) begin
            tick();
            req_arvalid_i = 3'b111;
            m_rvalid_i    = (mdl_own.size() > 0);
            m_rlast_i     = 1'b1;
            m_rdata_i     = {16{$urandom()}};
            m_rresp_i     = 2'(c);
        end
        tick();
        req_arvalid_i = 3'b000;
        m_rvalid_i    = 1'b0;
        m_rlast_i     = 1'b0;
        chk("t2_ngrants", glog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_order%0d", i), (i < glog.size()) ? glog[i] : -1, i % 3);
        end
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("t2_spacing%0d", i), (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : -1, 2);
        end

        // Fill the owner FIFO, then refill after one pop
        glog.delete();
        req_araddr_i = {64'h4200, 64'h4100, 64'h4000};
        req_arlen_i  = '0;
        for (int c = 0; c < 9; c++) begin
            tick();
            req_arvalid_i = 3'b111;
        end
        #5 chk("t3_full_block", req_arready_o, 3'b000);
        chk("t3_busy", busy_o, 1'b1);
        chk("t3_ngrants", glog.size(), 4);
        tick();
        m_rvalid_i = 1'b1;
        m_rlast_i  = 1'b1;
        #5 chk("t3_route_first", req_rvalid_o, 3'b001);
        chk("t3_no_same_cycle", req_arready_o, 3'b000);
        tick();
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        #5 chk("t3_refill", req_arready_o, 3'b010);
        tick();
        req_arvalid_i = 3'b000;
        pulse_reset();

        // Four-beat burst to owner 2 under backpressure
        tick();
        req_arvalid_i = 3'b100;
        req_araddr_i[2*AW +: AW] = 64'h2000;
        req_arlen_i[23:16] = 8'd3;
        #5 chk("t4_grant", req_arready_o, 3'b100);
        tick();
        req_arvalid_i = 3'b000;
        #5 chk("t4_arlen", m_arlen_o, 8'd3);
        chk("t4_araddr", m_araddr_o, 64'h2000);
        rdy_pat  = 6'b101101;
        last_pat = 6'b110000;
        for (int i = 0; i < 6; i++) begin
            tick();
            m_rvalid_i   = 1'b1;
            m_rlast_i    = last_pat[i];
            req_rready_i = {rdy_pat[i], ~rdy_pat[i], ~rdy_pat[i]};
            m_rdata_i    = {16{32'(i)}};
            #5 chk($sformatf("t4_m_rready%0d", i), m_rready_o, rdy_pat[i]);
            chk($sformatf("t4_owner%0d", i), req_rvalid_o, 3'b100);
            chk($sformatf("t4_busy%0d", i), busy_o, 1'b1);
        end
        tick();
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        #5 chk("t4_popped", busy_o, 1'b0);

        // Stray beat with empty FIFO
        tick();
        m_rvalid_i   = 1'b1;
        m_rlast_i    = 1'b1;
        req_rready_i = 3'b000;
        #5 chk("t5_stray_drain", m_rready_o, 1'b1);
        chk("t5_stray_rvalid", req_rvalid_o, 3'b000);
        chk("t5_err_pre", err_o, 1'b0);
        tick();
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        #5 chk("t5_err_set", err_o, 1'b1);
        repeat (3) tick();
        #5 chk("t5_err_sticky", err_o, 1'b1);

        // Reset in the middle of a burst
        tick();
        req_arvalid_i = 3'b001;
        req_araddr_i[AW-1:0] = 64'h3000;
        req_arlen_i[7:0] = 8'd3;
        req_rready_i = 3'b111;
        tick();
        req_arvalid_i = 3'b000;
        tick();
        m_rvalid_i = 1'b1;
        m_rlast_i  = 1'b0;
        tick();
        #5 chk("t5_midburst_owner", req_rvalid_o, 3'b001);
        tick();
        rst_ni = 1'b0;
        #5 chk("t5_rst_arvalid", m_arvalid_o, 1'b0);
        chk("t5_rst_araddr", m_araddr_o, 64'h0);
        chk("t5_rst_arlen", m_arlen_o, 8'd0);
        chk("t5_rst_busy", busy_o, 1'b0);
        chk("t5_rst_err", err_o, 1'b0);
        chk("t5_rst_m_rready", m_rready_o, 1'b1);
        chk("t5_rst_rvalid", req_rvalid_o, 3'b000);
        chk("t5_rst_arready", req_arready_o, 3'b000);
        tick();
        rst_ni     = 1'b1;
        m_rvalid_i = 1'b0;
        #5 chk("t5_post_busy", busy_o, 1'b0);
        chk("t5_post_err", err_o, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hawk_rd_arb.md
# hawk_rd_arb

Shared AXI4 read-channel arbiter for the hawk engine. It replaces the ad-hoc OR-ing of `arvalid` between managers such as the page-writer, compress and decompress managers. Up to NUM_REQ requesters present single-transaction AR requests. A round-robin grant registers the winner into one AR stage toward the memory port. An in-order owner FIFO steers R beats back to the requester that issued the matching AR. All transactions use AXI ID 0, so memory returns responses in issue order.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width
- OUTSTD, 4, owner-FIFO depth, i.e. maximum outstanding AR transactions (power of 2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_arvalid_i  in  NUM_REQ  per-requester AR valid
- req_araddr_i  in  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i
- req_arlen_i  in  NUM_REQ*8  per-requester burst length
- req_arready_o  out  NUM_REQ  one-hot grant
- req_rvalid_o  out  NUM_REQ  one-hot R valid, asserted to the head owner only
- req_rready_i  in  NUM_REQ  per-requester R ready
- rdata_o  out  DATA_W  broadcast copy of m_rdata_i
- rresp_o  out  2  broadcast copy of m_rresp_i
- rlast_o  out  1  broadcast copy of m_rlast_i
- m_arvalid_o  out  1  memory-side AR valid
- m_araddr_o  out  ADDR_W  memory-side AR address
- m_arlen_o  out  8  memory-side AR length
- m_arready_i  in  1  memory-side AR ready
- m_rvalid_i  in  1  memory-side R valid
- m_rdata_i  in  DATA_W  memory-side R data
- m_rresp_i  in  2  memory-side R response
- m_rlast_i  in  1  memory-side R last
- m_rready_o  out  1  memory-side R ready
- busy_o  out  1  high when the owner FIFO is non-empty or m_arvalid_o is high
- err_o  out  1  sticky; R beat arrived with the owner FIFO empty

## Operation
- **Grant condition.** can_grant = !m_arvalid_o && fifo_count < OUTSTD.
- **Winner selection.** The winner is the first requester with req_arvalid_i set, scanning from rr_ptr upward modulo NUM_REQ.
- **Grant output.** req_arready_o[w] = can_grant && req_arvalid_i[w]. It is combinational, and at most one bit is high.
- **On a grant (handshake with requester w):**
  - the AR stage loads req_araddr_i and req_arlen_i slice w and sets m_arvalid_o;
  - w is pushed into the owner FIFO;
  - rr_ptr <= (w+1) mod NUM_REQ.
- **AR hold.** m_arvalid_o, m_araddr_o and m_arlen_o hold stable until m_arvalid_o && m_arready_i, then m_arvalid_o clears.
- **R routing.** head = owner FIFO head.
  - FIFO non-empty: req_rvalid_o[head] = m_rvalid_i, and m_rready_o = req_rready_i[head].
  - FIFO empty: req_rvalid_o = 0 and m_rready_o = 1, so stray beats are drained. Any m_rvalid_i in this condition sets err_o until reset.
- **Pop.** The owner FIFO pops on m_rvalid_i && m_rready_o && m_rlast_i with the FIFO non-empty. Multi-beat bursts stay with the same owner until rlast.
- **Simultaneous push and pop.** Both take effect in the same cycle; the count is unchanged.
- **Requester rules.** Requesters assert valid without waiting for ready. A requester must hold valid and payload until its grant.
- **Pipeline state.** There is no FSM beyond the AR-stage valid bit plus the FIFO pointers and count (width clog2(OUTSTD)+1). Read and write pointers wrap modulo OUTSTD.

## Timing
- **Reset values.**
  - Registers: m_arvalid_o=0, m_araddr_o=0, m_arlen_o=0, rr_ptr=0, FIFO empty (count 0), err_o=0.
  - Derived outputs: req_arready_o=0 until a req_arvalid_i is seen, req_rvalid_o=0, m_rready_o=1, busy_o=0.
- **Mid-operation reset.** Reset clears all state immediately. Transactions in flight are dropped, and no replay is attempted.
- **Issue latency.** A grant in cycle N gives m_arvalid_o=1 in cycle N+1. If m_arready_i=1 in N+1, the next grant is possible in N+2. Best-case AR throughput is one request per 2 cycles.
- **FIFO full.** With count == OUTSTD there are no grants. A pop in cycle N re-enables grants in N+1, not in N.
- **R path latency.** The R path is combinational: zero added latency and no buffering. Backpressure from the head owner propagates directly to m_rready_o.

## Test plan
- **Single request.** Only requester 1 requests addr 0x1000, arlen 0, with m_arready_i=1.
  - req_arready_o=3'b010 in cycle 0.
  - m_arvalid_o with addr 0x1000 in cycle 1.
  - A 1-beat R with rlast raises req_rvalid_o=3'b010; FIFO returns to empty and busy_o=0.
- **Round-robin fairness.** All three requesters hold valid continuously, memory always ready.
  - Grant order 0,1,2,0,1,2, one grant every 2 cycles.
- **Full and refill.** OUTSTD=4, four ARs issued, no R returned.
  - 5th request sees req_arready_o=0.
  - Return one 1-beat rlast response: grant appears the following cycle, and it routes to the first issued owner.
- **Backpressure and burst.** Owner 2 issues an AR with arlen 3; memory sends 4 beats while req_rready_i[2] toggles 1,0,1.
  - m_rready_o tracks req_rready_i[2].
  - Owner stays 2 across all beats and pops only on rlast.
- **Stray beat and mid-burst reset.** First, drive m_rvalid_i with the FIFO empty. Second, assert rst_ni low in the middle of a burst.
  - Stray beat: m_rready_o=1 and err_o=1 sticky.
  - Mid-burst reset: all outputs return to their reset values and err_o clears.
